// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Owns the reset of one PLL and the resets of the clock domains it feeds.
//   Holds the PLL in reset, waits for lock, requires lock to stay up for a
//   stability window, then releases the domain resets one by one. Lock loss
//   re-asserts every domain reset and waits for relock. A lock timeout
//   re-resets the PLL.
//
// Ports
//   refclk           in   free-running reference clock, sole clock
//   rst              in   asynchronous active-high reset
//   pll_locked       in   PLL locked, asynchronous (2-FF synchronised here)
//   restart          in   single-cycle request for a full PLL reset sequence
//   clear_counts     in   single-cycle request to zero the event counters
//   pll_rst          out  reset to the PLL
//   domain_rst       out  per-domain active-high resets, bit 0 released first
//   ready            out  high only in RUN
//   state            out  FSM state (0 PLL_RESET .. 4 RUN)
//   lock_loss_count  out  lock losses seen in RELEASE/RUN, saturating
//   retry_count      out  lock timeouts, saturating
module pll_lock_supervisor #(
  parameter int unsigned NUM_DOMAINS         = 3,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 5000,
  parameter int unsigned RELEASE_SPACING     = 64
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   restart,
  input  logic                   clear_counts,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [2:0]             state,
  output logic [7:0]             lock_loss_count,
  output logic [7:0]             retry_count
);

  localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * RELEASE_SPACING;
  localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_B > REL_SPAN + 1) ? MAX_B : REL_SPAN + 1;
  localparam int unsigned CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(REL_SPAN);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             sync_q;
  logic                   lk;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             loss_cnt_q, loss_cnt_d;
  logic [7:0]             retry_cnt_q, retry_cnt_d;
  logic                   loss_ev, retry_ev;

  assign lk = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= S_PLL_RESET;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
      retry_cnt_q  <= '0;
    end else begin
      sync_q       <= {sync_q[0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  // Next state and shared phase counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_ev  = 1'b0;
    retry_ev = 1'b0;
    if (restart) begin
      state_d = S_PLL_RESET;
      cnt_d   = '0;
      loss_ev = !lk && (state_q == S_RELEASE || state_q == S_RUN);
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == PRST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // The WAIT_LOCK cycle that first sees lk already counts as one
          // stable cycle, so STABLE is entered with the count at 1.
          if (lk) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              state_d = S_RELEASE;
              cnt_d   = '0;
            end else begin
              state_d = S_STABLE;
              cnt_d   = CW'(1);
            end
          end else if (cnt_q == TO_LAST) begin
            state_d  = S_PLL_RESET;
            cnt_d    = '0;
            retry_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STAB_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            loss_ev = 1'b1;
          end else if (cnt_q == REL_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            loss_ev = 1'b1;
          end
        end
        default: begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  always_comb begin
    pll_rst_d    = (state_d == S_PLL_RESET);
    ready_d      = (state_d == S_RUN);
    domain_rst_d = '1;
    if (state_d == S_RUN) begin
      domain_rst_d = '0;
    end else if (state_d == S_RELEASE) begin
      for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
        domain_rst_d[k] = (cnt_d < CW'(k * RELEASE_SPACING));
      end
    end
  end

  // Saturating event counters; clear overrides a coincident increment
  always_comb begin
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (clear_counts) begin
      loss_cnt_d  = '0;
      retry_cnt_d = '0;
    end else begin
      if (loss_ev && loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
      if (retry_ev && retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign domain_rst      = domain_rst_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;
  assign retry_count     = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenario tasks with
// timing expectations taken from the block's behaviour, plus a randomized run
// checked against a timeline model of the supervisor.
module tb_pll_lock_supervisor;

  localparam int ND   = 3;
  localparam int PRST = 4;
  localparam int TO   = 32;
  localparam int LS   = 8;
  localparam int SP   = 2;
  localparam int VW   = ND + 21;

  logic          refclk, rst, pll_locked, restart, clear_counts;
  logic          pll_rst, ready;
  logic [ND-1:0] domain_rst;
  logic [2:0]    state;
  logic [7:0]    lock_loss_count, retry_count;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .NUM_DOMAINS(ND), .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(LS), .RELEASE_SPACING(SP)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .clear_counts(clear_counts), .pll_rst(pll_rst), .domain_rst(domain_rst),
    .ready(ready), .state(state), .lock_loss_count(lock_loss_count),
    .retry_count(retry_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Timeline model: phase number, cycle the phase began, consecutive-lock streak
  int   m_ph = 0, m_now = 0, m_t0 = 0, m_streak = 0, m_loss = 0, m_retry = 0;
  int   m_el, m_nph;
  logic m_h1 = 1'b0, m_h2 = 1'b0, m_lk, m_lossev, m_retryev;

  initial forever begin
    @(posedge refclk or posedge rst);
    if (rst) begin
      m_ph = 0; m_now = 0; m_t0 = 0; m_streak = 0; m_loss = 0; m_retry = 0;
      m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      m_lk = m_h2; m_h2 = m_h1; m_h1 = pll_locked;
      m_el = m_now - m_t0;
      m_nph = m_ph;
      m_lossev  = !m_lk && (m_ph == 3 || m_ph == 4);
      m_retryev = 1'b0;
      if (restart) m_nph = 0;
      else begin
        case (m_ph)
          0: if (m_el + 1 >= PRST) m_nph = 1;
          1: begin
            if (m_lk) m_nph = (LS <= 1) ? 3 : 2;
            else if (m_el + 1 >= TO) begin m_nph = 0; m_retryev = 1'b1; end
          end
          2: begin
            if (!m_lk) m_nph = 1;
            else if (m_streak + 1 >= LS) m_nph = 3;
          end
          3: begin
            if (m_lossev) m_nph = 1;
            else if (m_el >= (ND - 1) * SP) m_nph = 4;
          end
          4: if (m_lossev) m_nph = 1;
          default: m_nph = 0;
        endcase
      end
      m_streak = !m_lk ? 0 : (m_ph == 2) ? m_streak + 1 : 1;
      if (clear_counts) begin
        m_loss = 0; m_retry = 0;
      end else begin
        if (m_lossev && m_loss < 255) m_loss++;
        if (m_retryev && m_retry < 255) m_retry++;
      end
      m_now++;
      if (restart || m_nph != m_ph) m_t0 = m_now;
      m_ph = m_nph;
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [ND-1:0] d;
    int el;
    el = m_now - m_t0;
    for (int k = 0; k < ND; k++)
      d[k] = (m_ph == 4) ? 1'b0 : (m_ph == 3) ? (el < k * SP) : 1'b1;
    return {m_ph == 0, d, m_ph == 4, 3'(m_ph), 8'(m_loss), 8'(m_retry)};
  endfunction

  // Expected domain_rst i cycles after pll_locked rises while in WAIT_LOCK
  function automatic logic [ND-1:0] rel_dom(int i);
    logic [ND-1:0] d;
    for (int k = 0; k < ND; k++) d[k] = !(i >= LS + 2 + k * SP);
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0; clear_counts = 1'b0;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0; clear_counts = 1'b0;
    #1;
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst: got=%b exp=1", pll_rst); end
    total++; if (domain_rst !== '1) begin bad++; $display("FAIL reset_domain_rst: got=%b exp=111", domain_rst); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b exp=0", ready); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got=%0d exp=0", state); end
    total++; if (lock_loss_count !== 8'd0) begin bad++; $display("FAIL reset_loss: got=%0d exp=0", lock_loss_count); end
    total++; if (retry_count !== 8'd0) begin bad++; $display("FAIL reset_retry: got=%0d exp=0", retry_count); end
    repeat (3) @(negedge refclk);
    total++; if (state !== 3'd0 || pll_rst !== 1'b1) begin bad++; $display("FAIL reset_held: got state=%0d pll_rst=%b exp state=0 pll_rst=1", state, pll_rst); end
  endtask

  task automatic test_nominal();
    int n;
    do_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin n++; @(negedge refclk); end
    total++; if (n != PRST) begin bad++; $display("FAIL nom_pll_rst_len: got=%0d exp=%0d", n, PRST); end
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge refclk);
      total++; if (domain_rst !== rel_dom(i)) begin bad++; $display("FAIL nom_domain i=%0d: got=%b exp=%b", i, domain_rst, rel_dom(i)); end
      total++; if (ready !== (i >= LS + 3 + (ND - 1) * SP)) begin bad++; $display("FAIL nom_ready i=%0d: got=%b exp=%b", i, ready, i >= LS + 3 + (ND - 1) * SP); end
    end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL nom_state: got=%0d exp=4", state); end
    total++; if (lock_loss_count !== 8'd0 || retry_count !== 8'd0) begin bad++; $display("FAIL nom_counts: got=%0d/%0d exp=0/0", lock_loss_count, retry_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int n = 0; n < 108; n++) begin
      total++; if (pll_rst !== ((n % 36) < PRST)) begin bad++; $display("FAIL to_pll_rst n=%0d: got=%b exp=%b", n, pll_rst, (n % 36) < PRST); end
      total++; if (retry_count !== 8'(n / 36)) begin bad++; $display("FAIL to_retry n=%0d: got=%0d exp=%0d", n, retry_count, n / 36); end
      @(negedge refclk);
    end
    total++; if (retry_count !== 8'd3) begin bad++; $display("FAIL to_retry3: got=%0d exp=3", retry_count); end
    repeat (36 * 255) @(negedge refclk);
    total++; if (retry_count !== 8'd255) begin bad++; $display("FAIL to_saturate: got=%0d exp=255", retry_count); end
    total++; if (lock_loss_count !== 8'd0) begin bad++; $display("FAIL to_loss: got=%0d exp=0", lock_loss_count); end
    clear_counts = 1'b1;
    @(negedge refclk);
    clear_counts = 1'b0;
    total++; if (retry_count !== 8'd0) begin bad++; $display("FAIL to_clear: got=%0d exp=0", retry_count); end
  endtask

  task automatic test_loss_run();
    int n;
    do_reset();
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd4 && n < 100) begin n++; @(negedge refclk); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL loss_reach_run: got=%0d exp=4", state); end
    pll_locked = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge refclk);
      if (j < 3) begin
        total++; if (domain_rst !== '0 || ready !== 1'b1) begin bad++; $display("FAIL loss_early j=%0d: got dom=%b rdy=%b exp dom=000 rdy=1", j, domain_rst, ready); end
      end else begin
        total++; if (domain_rst !== '1) begin bad++; $display("FAIL loss_domain: got=%b exp=111", domain_rst); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_ready: got=%b exp=0", ready); end
        total++; if (lock_loss_count !== 8'd1) begin bad++; $display("FAIL loss_count: got=%0d exp=1", lock_loss_count); end
        total++; if (state !== 3'd1) begin bad++; $display("FAIL loss_state: got=%0d exp=1", state); end
      end
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge refclk);
      total++; if (domain_rst !== rel_dom(i)) begin bad++; $display("FAIL relock_domain i=%0d: got=%b exp=%b", i, domain_rst, rel_dom(i)); end
    end
    total++; if (state !== 3'd4 || lock_loss_count !== 8'd1) begin bad++; $display("FAIL relock_end: got state=%0d loss=%0d exp state=4 loss=1", state, lock_loss_count); end
  endtask

  task automatic test_glitch();
    int n;
    localparam int GL = 5;
    do_reset();
    n = 0;
    while (state !== 3'd1 && n < 20) begin n++; @(negedge refclk); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL gl_wait_lock: got=%0d exp=1", state); end
    pll_locked = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge refclk);
      total++; if (domain_rst[0] !== (i < GL + 1 + LS + 2)) begin bad++; $display("FAIL gl_dom0 i=%0d: got=%b exp=%b", i, domain_rst[0], i < GL + 1 + LS + 2); end
      if (i == GL) pll_locked = 1'b0;
      if (i == GL + 1) pll_locked = 1'b1;
    end
    total++; if (lock_loss_count !== 8'd0) begin bad++; $display("FAIL gl_loss: got=%0d exp=0", lock_loss_count); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL gl_state: got=%0d exp=4", state); end
  endtask

  task automatic test_restart_clear();
    int n;
    do_reset();
    pll_locked = 1'b1;
    n = 0;
    while (domain_rst !== 3'b110 && n < 60) begin n++; @(negedge refclk); end
    total++; if (domain_rst !== 3'b110) begin bad++; $display("FAIL rs_mid_release: got=%b exp=110", domain_rst); end
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    total++; if (domain_rst !== 3'b111) begin bad++; $display("FAIL rs_domain: got=%b exp=111", domain_rst); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rs_state: got=%0d exp=0", state); end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin n++; @(negedge refclk); end
    total++; if (n != PRST) begin bad++; $display("FAIL rs_pll_rst_len: got=%0d exp=%0d", n, PRST); end
    n = 0;
    while (state !== 3'd4 && n < 60) begin n++; @(negedge refclk); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL rs_run1: got=%0d exp=4", state); end
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    total++; if (lock_loss_count !== 8'd1) begin bad++; $display("FAIL rs_loss1: got=%0d exp=1", lock_loss_count); end
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd4 && n < 60) begin n++; @(negedge refclk); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL rs_run2: got=%0d exp=4", state); end
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    clear_counts = 1'b1;
    @(negedge refclk);
    clear_counts = 1'b0;
    total++; if (lock_loss_count !== 8'd0) begin bad++; $display("FAIL rs_clear_wins: got=%0d exp=0", lock_loss_count); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rs_loss_state: got=%0d exp=1", state); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd4 && n < 60) begin n++; @(negedge refclk); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ar_run: got=%b exp=1", ready); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL ar_pll_rst: got=%b exp=1", pll_rst); end
    total++; if (domain_rst !== '1) begin bad++; $display("FAIL ar_domain: got=%b exp=111", domain_rst); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got=%b exp=0", ready); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL ar_state: got=%0d exp=0", state); end
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [VW-1:0] expv, got;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge refclk);
      expv = model_vec();
      got  = {pll_rst, domain_rst, ready, state, lock_loss_count, retry_count};
      total++; if (got !== expv) begin bad++; $display("FAIL random c=%0d: got=%h exp=%h", c, got, expv); end
      if (pll_locked) begin
        if ($urandom_range(0, 999) < 15) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 999) < 80) pll_locked = 1'b1;
      end
      restart      = ($urandom_range(0, 999) < 8);
      clear_counts = ($urandom_range(0, 999) < 5);
    end
    restart = 1'b0;
    clear_counts = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_loss_run();
    test_glitch();
    test_restart_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised PLL supervisor. It drives the reset of an `altera_pll` instance and watches its `locked` output. Once lock has been stable for a set time, it releases per-domain resets one after another. On loss of lock it re-asserts all domain resets and retries the PLL. It sits beside each PLL wrapper in `soc_system` (ADC PLL and others) and is the single owner of clock-domain reset release; the HPS can read its status through a PIO.

## Interface
- `NUM_DOMAINS`, 3: number of downstream domain resets, 1..8.
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset, ≥1.
- `LOCK_TIMEOUT_CYCLES`, 500000: cycles to wait for lock before re-resetting the PLL, ≥2.
- `LOCK_STABLE_CYCLES`, 5000: consecutive synchronised-lock cycles required before release, ≥1.
- `RELEASE_SPACING`, 64: cycles between successive domain releases, ≥1.

- `refclk`  in  1  free-running reference clock (the PLL's `refclk`); sole clock of this block.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked`, asynchronous; synchronised internally with a 2-FF chain.
- `restart`  in  1  single-cycle request to force a full PLL reset sequence.
- `clear_counts`  in  1  single-cycle request to zero both event counters.
- `pll_rst`  out  1  reset to the PLL `rst` port.
- `domain_rst`  out  NUM_DOMAINS  active-high resets to the PLL output-clock domains, bit 0 released first.
- `ready`  out  1  high only in RUN.
- `state`  out  3  encoded FSM state: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- `lock_loss_count`  out  8  lock losses seen in RELEASE/RUN; saturates at 255.
- `retry_count`  out  8  lock timeouts; saturates at 255.

## Operation
- All outputs are registered. Reset values:
  - `pll_rst`=1
  - `domain_rst`=all 1
  - `ready`=0
  - `state`=PLL_RESET
  - both counters=0
  - sync chain=0
- `lk` is the synchronised lock. It lags `pll_locked` by 2 cycles.
- **PLL_RESET:** `pll_rst`=1 and all `domain_rst`=1. Stays for exactly `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0 and all `domain_rst`=1. The cycle counter starts at 0 on entry.
  - `lk`=1 goes to STABLE.
  - If the counter reaches `LOCK_TIMEOUT_CYCLES`-1 with `lk`=0, go to PLL_RESET and increment `retry_count`.
- **STABLE:** counts consecutive `lk`=1 cycles.
  - After `LOCK_STABLE_CYCLES` such cycles, go to RELEASE.
  - `lk`=0 goes to WAIT_LOCK. The timeout counter restarts and no counter increments.
- **RELEASE:** `domain_rst[k]` falls `k*RELEASE_SPACING` cycles after the first RELEASE cycle (bit 0 falls on that first cycle). RUN is entered the cycle after bit `NUM_DOMAINS`-1 falls.
- **RUN:** `ready`=1 and all `domain_rst`=0.
- **Lock loss:** `lk`=0 in RELEASE or RUN causes the following on the next edge:
  - all `domain_rst`=1 and `ready`=0;
  - `lock_loss_count` increments;
  - the FSM goes to WAIT_LOCK (the PLL is not reset).
- **Restart:** `restart`=1 in any state goes to PLL_RESET on the next edge. All `domain_rst` are re-asserted and the PLL_RST_CYCLES count restarts. `restart` has priority over every other transition. A lock loss in the same cycle still increments `lock_loss_count`.
- **Clear:** `clear_counts` zeroes both counters on the next edge. If it coincides with an increment, clear wins and the result is 0.
- **Counter widths:** internal counters are `$clog2(max param)+1` bits and must not wrap. The event counters hold at 255.

## Timing
- `pll_locked` rising is seen as `lk` 2 cycles later. The first `domain_rst[0]` fall is `2+LOCK_STABLE_CYCLES` cycles after `pll_locked` rises, provided the FSM was waiting in WAIT_LOCK.
- Lock-loss reaction: `domain_rst` asserts 3 edges after `pll_locked` falls (2 sync plus 1 register).
- Deasserting `rst` is treated as asynchronous. The first PLL_RESET cycle is the first edge after release.
- A single-cycle glitch of `lk` low in STABLE restarts the full stability count.

## Test plan
All scenarios use `NUM_DOMAINS`=3, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `RELEASE_SPACING`=2.
- **Nominal bring-up:** release `rst`; raise `pll_locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` is high for 4 cycles.
  - `domain_rst` bits fall at lock+10, +12 and +14.
  - `ready` rises at lock+15.
  - Counters stay 0.
- **Timeout:** hold `pll_locked`=0.
  - `pll_rst` pulses for 4 cycles every 36 cycles.
  - `retry_count` reaches 3 after 3 pulses.
  - It saturates at 255 over a long run.
- **Loss in RUN:** drop `pll_locked` while in RUN.
  - All `domain_rst`=1 and `ready`=0 exactly 3 edges later.
  - `lock_loss_count`=1 and `state`=1.
  - Relock produces the full release sequence again.
- **Glitch in STABLE:** drop `lk` for 1 cycle at stable count 5.
  - No release until 8 further consecutive cycles of `lk`=1.
  - `lock_loss_count` stays 0.
- **Restart and clear:** pulse `restart` mid-RELEASE with `domain_rst`=3'b110.
  - Next edge gives `domain_rst`=3'b111 and `pll_rst`=1 for 4 cycles.
  - Pulsing `clear_counts` in the same cycle as a lock loss leaves `lock_loss_count`=0.
- **Async reset mid-RUN:** assert `rst` while in RUN.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
